hs4_tx_fifo: RTL and testbench

- Source-side transmitter for a 4-phase (return-to-zero) req/ack handshake, generalised in data width, buffer depth, synchroniser depth and inter-transfer gap.
- Local logic pushes words through a valid/ready interface into an internal FIFO.
- The block drains the FIFO one word per full handshake to a receiver in a foreign clock domain, and synchronises the incoming ack internally.
- Unlike a level/edge-only sender, it waits for ack to return low before starting the next word, and it buffers bursts.

---
 rtl/hs4_pkg.sv | 18 +
 rtl/hs_sync.sv | 26 ++
 rtl/hs4_tx_fifo.sv | 141 ++++++++++++++
 tb/tb_hs4_tx_fifo.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// hs4_pkg: definitions shared by the 4-phase handshake transmitter
// (hs4_tx_fifo) and the future matching receiver.
//   state_e : handshake FSM states, 2-bit encoding
//   ptr_w() : FIFO pointer width for a power-of-two depth
package hs4_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    GAP     = 2'd3
  } state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, all flops cleared to 0
//   d   : asynchronous input level
//   q   : synchronised level, STAGES clk edges behind d
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the value its neighbour held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/hs4_tx_fifo.sv
// hs4_tx_fifo: buffered source side of a 4-phase (return-to-zero) req/ack
// handshake. Local words enter a FIFO through valid/ready and are sent one
// per full handshake to a receiver in a foreign clock domain.
// Optional feature: define HS4_TX_TIMEOUT_EN to add the sticky 'timeout'
// output, set after TIMEOUT consecutive cycles spent waiting in REQ.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : local word offered        in_ready : FIFO not full
//   in_data   : local word
//   data_req  : registered request         data_out : registered word
//   data_ack  : receiver acknowledge (asynchronous to clk)
//   level     : FIFO occupancy 0..DEPTH    busy     : FSM not in IDLE
//   done      : one-cycle pulse when the ack of a word is seen high
//   timeout   : (HS4_TX_TIMEOUT_EN only) sticky REQ-dwell timeout
module hs4_tx_fifo #(
  parameter int DW          = 4,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GAP         = 5,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     data_req,
  output logic [DW-1:0]            data_out,
  input  logic                     data_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     done
`ifdef HS4_TX_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  import hs4_pkg::*;

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);

  // The parameter GAP hides the enum literal of the same name, so that
  // state is always written package-qualified below.
  state_e          state, state_n;
  logic            ack_s;
  logic            push, pop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   gap_cnt;
  logic [DW-1:0]   mem [DEPTH];

  hs_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_ack),
    .q   (ack_s)
  );

  // No bypass: a full FIFO refuses the push even if a pop happens that cycle.
  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A stale ack still high in IDLE blocks the next request.
  assign pop      = (state == IDLE) && (level != '0) && !ack_s;
  assign busy     = (state != IDLE);

  // NOTE: the storage array has no reset; words are only read after being
  // written, and occupancy is tracked by the reset pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop)    state_n = REQ;
      REQ:     if (ack_s)  state_n = RELEASE;
      RELEASE: if (!ack_s) state_n = (GAP == 0) ? IDLE : hs4_pkg::GAP;
      hs4_pkg::GAP: if (gap_cnt == GAP_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_req <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      data_req <= (state_n == REQ);
      done     <= (state == REQ) && ack_s;
      // data_out changes only when a word is popped on the IDLE->REQ edge.
      if (pop) data_out <= mem[rd_ptr];
      gap_cnt  <= (state == hs4_pkg::GAP) ? gap_cnt + CW'(1) : '0;
    end
  end

`ifdef HS4_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] DWELL_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TW-1:0] dwell;

  // dwell counts completed cycles in REQ; the TIMEOUT-th one sets the flag,
  // which stays set until reset while the handshake continues unaffected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      timeout <= 1'b0;
    end else begin
      if (state != REQ)             dwell <= '0;
      else if (dwell != DWELL_LAST) dwell <= dwell + TW'(1);
      if ((state == REQ) && (dwell == DWELL_LAST)) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs4_tx_fifo.sv
module tb_hs4_tx_fifo;

`ifdef HS4_TX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic       clk = 1'b0;
  logic       clk_b = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       data_req;
  logic [3:0] data_out;
  logic       data_ack;
  logic [3:0] level;
  logic       busy;
  logic       done;
`ifdef HS4_TX_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Acknowledge comes either from the directed driver or the receiver model.
  logic       man_ack;
  logic       rx_en;
  logic       rx_ack = 1'b0;
  int         rx_wait = 0;
  logic [3:0] rx_q[$];

  assign data_ack = rx_en ? rx_ack : man_ack;

  always #5 clk = ~clk;
  always #7 clk_b = ~clk_b;

  hs4_tx_fifo #(
    .DW(4), .DEPTH(8), .SYNC_STAGES(2), .GAP(5), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .data_req (data_req),
    .data_out (data_out),
    .data_ack (data_ack),
    .level    (level),
    .busy     (busy),
    .done     (done)
`ifdef HS4_TX_TIMEOUT_EN
    ,
    .timeout  (timeout)
`endif
  );

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Receiver in clk_b: ack 3 clk_b edges after seeing req, capture the word,
  // drop ack once req has returned low.
  always @(posedge clk_b) begin
    if (!rx_en) begin
      rx_ack  <= 1'b0;
      rx_wait <= 0;
    end else if (!rx_ack) begin
      if (data_req) begin
        if (rx_wait == 2) begin
          rx_ack  <= 1'b1;
          rx_q.push_back(data_out);
          rx_wait <= 0;
        end else begin
          rx_wait <= rx_wait + 1;
        end
      end else begin
        rx_wait <= 0;
      end
    end else if (!data_req) begin
      rx_ack <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    while (data_req !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (data_req !== 1'b0) begin
      errors++;
      $display("FAIL %s: data_req=%b required 0 within 20 cycles", name, data_req);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(busy === 1'b0 && level === 4'd0) && n < budget) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL %s: busy=%b level=%0d required idle and empty within %0d cycles",
               name, busy, level, budget);
    end
  endtask

  task automatic handshake_manual(input string name);
    man_ack = 1'b1;
    wait_req_low(name);
    man_ack = 1'b0;
    wait_idle(40, name);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", data_req); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data: got %h required 0", data_out); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int d0;
    bit bad;
    d0 = done_cnt;
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 4'd1 || data_req !== 1'b0) begin errors++; $display("FAIL single_push: level=%0d req=%b required 1/0", level, data_req); end
    tick();
    checks++; if (data_req !== 1'b1 || data_out !== 4'h3 || level !== 4'd0) begin errors++; $display("FAIL single_req: req=%b data=%h level=%0d required 1/3/0", data_req, data_out, level); end
    repeat (3) tick();
    checks++; if (data_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_hold: req=%b done=%b required 1/0", data_req, done); end
    man_ack = 1'b1;
    // ack_s rises after SYNC_STAGES edges; the FSM reacts on the next one.
    repeat (2) tick();
    checks++; if (data_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_sync: req=%b done=%b required 1/0", data_req, done); end
    tick();
    checks++; if (data_req !== 1'b0 || done !== 1'b1 || data_out !== 4'h3) begin errors++; $display("FAIL single_ack: req=%b done=%b data=%h required 0/1/3", data_req, done, data_out); end
    // Queue a second word while the first is still releasing.
    in_valid = 1'b1; in_data = 4'hA;
    tick();
    in_valid = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1 || level !== 4'd1) begin errors++; $display("FAIL single_release: done=%b busy=%b level=%0d required 0/1/1", done, busy, level); end
    man_ack = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL single_gap_entry: busy=%b req=%b required 1/0", busy, data_req); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (data_req !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad || busy !== 1'b0) begin errors++; $display("FAIL single_gap: early_req=%b busy=%b required 0/0", bad, busy); end
    tick();
    checks++; if (data_req !== 1'b1 || data_out !== 4'hA) begin errors++; $display("FAIL single_next: req=%b data=%h required 1/a", data_req, data_out); end
    handshake_manual("single_finish");
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL single_done_count: got %0d required 2", done_cnt - d0); end
  endtask

  task automatic test_stale_ack();
    bit bad;
    rst = 1'b1; man_ack = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    in_valid = 1'b1; in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (data_req !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad || level !== 4'd1) begin errors++; $display("FAIL stale_hold: early_req=%b level=%0d required 0/1", bad, level); end
    man_ack = 1'b0;
    repeat (2) tick();
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL stale_sync: req=%b required 0", data_req); end
    tick();
    checks++; if (data_req !== 1'b1 || data_out !== 4'h6) begin errors++; $display("FAIL stale_release: req=%b data=%h required 1/6", data_req, data_out); end
    handshake_manual("stale_finish");
  endtask

  task automatic test_burst();
    int d0;
    // Hold ack high so nothing drains while the FIFO fills.
    man_ack = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      checks++; if (level !== 4'(i + 1)) begin errors++; $display("FAIL burst_fill%0d: level=%0d required %0d", i, level, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_full_ready: got %b required 0", in_ready); end
    in_data = 4'h9;
    tick();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL burst_ninth: level=%0d required 8", level); end
    // Full FIFO with in_valid held: the pop frees a slot but no push lands.
    in_data = 4'hF;
    man_ack = 1'b0;
    repeat (2) tick();
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL full_wait: level=%0d required 8", level); end
    tick();
    in_valid = 1'b0;
    checks++; if (level !== 4'd7 || data_req !== 1'b1 || data_out !== 4'h0) begin errors++; $display("FAIL full_pop: level=%0d req=%b data=%h required 7/1/0", level, data_req, data_out); end
    d0 = done_cnt;
    rx_q.delete();
    rx_en = 1'b1;
    wait_idle(600, "burst_drain");
    rx_en = 1'b0;
    tick();
    checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL burst_count: got %0d words required 8", rx_q.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < rx_q.size()) begin
        checks++; if (rx_q[i] !== 4'(i)) begin errors++; $display("FAIL burst_word%0d: got %h required %h", i, rx_q[i], 4'(i)); end
      end
    end
    checks++; if (done_cnt - d0 !== 8) begin errors++; $display("FAIL burst_done: got %0d pulses required 8", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    bit bad;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      if (i == 2) begin
        checks++; if (level !== 4'd1 || data_req !== 1'b1) begin errors++; $display("FAIL push_pop_same: level=%0d req=%b required 1/1", level, data_req); end
      end
    end
    in_valid = 1'b0;
    checks++; if (level !== 4'd3 || data_req !== 1'b1 || data_out !== 4'h1) begin errors++; $display("FAIL mid_setup: level=%0d req=%b data=%h required 3/1/1", level, data_req, data_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || level !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: req=%b level=%0d busy=%b required 0/0/0", data_req, level, busy); end
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_req !== 1'b0 || level !== 4'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL mid_after: req or level nonzero after release, required 0"); end
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (data_req !== 1'b1 || data_out !== 4'h5) begin errors++; $display("FAIL mid_new: req=%b data=%h required 1/5", data_req, data_out); end
    handshake_manual("mid_finish");
  endtask

`ifdef HS4_TX_TIMEOUT_EN
  task automatic test_timeout();
    in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (9) tick();
    checks++; if (timeout !== 1'b0 || data_req !== 1'b1) begin errors++; $display("FAIL timeout_early: timeout=%b req=%b required 0/1", timeout, data_req); end
    tick();
    checks++; if (timeout !== 1'b1 || data_req !== 1'b1) begin errors++; $display("FAIL timeout_set: timeout=%b req=%b required 1/1", timeout, data_req); end
    handshake_manual("timeout_finish");
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b required 1", timeout); end
    rst = 1'b1;
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b required 0", timeout); end
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; man_ack = 1'b0; rx_en = 1'b0;
    test_reset();
    test_single();
    test_stale_ack();
    test_burst();
    test_reset_mid();
`ifdef HS4_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
